// File: rtl/mem_access_ctrl_if.sv
// Request/response and data-memory signals of mem_access_ctrl.
// The slave modport is the controller; the master modport is the requester together with the memory.
interface mem_access_ctrl_if #(
    parameter int unsigned ADDR_W = 64
);
    logic              start;
    logic              is_store;
    logic [1:0]        size;
    logic              is_unsigned;
    logic [ADDR_W-1:0] addr;
    logic [63:0]       store_data;
    logic [63:0]       mem_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic [63:0]       mem_wdata;
    logic [63:0]       load_data;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, is_store, size, is_unsigned, addr, store_data, mem_rdata,
        input  mem_addr, mem_wr, mem_wdata, load_data, busy, done, err
    );

    modport slave (
        input  start, is_store, size, is_unsigned, addr, store_data, mem_rdata,
        output mem_addr, mem_wr, mem_wdata, load_data, busy, done, err
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store controller for a 64-bit data memory with one-cycle read latency.
// Sub-doubleword stores are done as read-modify-write; misaligned requests complete with err.
module mem_access_ctrl #(
    parameter int unsigned ADDR_W = 64
) (
    input  logic             clock,
    input  logic             reset,
    mem_access_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD, CAP, WR, DONE} state_e;

    state_e            state_q, state_d;
    logic              is_store_q, is_store_d;
    logic [1:0]        size_q, size_d;
    logic              is_unsigned_q, is_unsigned_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [63:0]       store_data_q, store_data_d;

    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_wr_q, mem_wr_d;
    logic [63:0]       mem_wdata_q, mem_wdata_d;
    logic [63:0]       load_data_q, load_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [5:0]        shamt;
    logic [7:0]        byte_en;
    logic [63:0]       bit_mask;
    logic [63:0]       rdata_sh;
    logic [63:0]       load_ext;
    logic [63:0]       merged;

    function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] a);
        case (sz)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = a[0];
            2'b10:   misaligned = (a[1:0] != 2'b00);
            default: misaligned = (a != 3'b000);
        endcase
    endfunction

    function automatic logic [7:0] size_bytes(input logic [1:0] sz);
        case (sz)
            2'b00:   size_bytes = 8'h01;
            2'b01:   size_bytes = 8'h03;
            2'b10:   size_bytes = 8'h0F;
            default: size_bytes = 8'hFF;
        endcase
    endfunction

    // Lane extraction for loads and byte-lane merge for read-modify-write stores.
    always_comb begin
        shamt    = {addr_q[2:0], 3'b000};
        byte_en  = 8'(size_bytes(size_q) << addr_q[2:0]);
        bit_mask = '0;
        for (int i = 0; i < 8; i++) begin
            bit_mask[8*i +: 8] = {8{byte_en[i]}};
        end
        merged   = (bus.mem_rdata & ~bit_mask) | ((store_data_q << shamt) & bit_mask);
        rdata_sh = bus.mem_rdata >> shamt;
        case (size_q)
            2'b00:   load_ext = is_unsigned_q ? {56'd0, rdata_sh[7:0]}
                                              : {{56{rdata_sh[7]}}, rdata_sh[7:0]};
            2'b01:   load_ext = is_unsigned_q ? {48'd0, rdata_sh[15:0]}
                                              : {{48{rdata_sh[15]}}, rdata_sh[15:0]};
            2'b10:   load_ext = is_unsigned_q ? {32'd0, rdata_sh[31:0]}
                                              : {{32{rdata_sh[31]}}, rdata_sh[31:0]};
            default: load_ext = bus.mem_rdata;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        is_store_d    = is_store_q;
        size_d        = size_q;
        is_unsigned_d = is_unsigned_q;
        addr_d        = addr_q;
        store_data_d  = store_data_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        load_data_d   = load_data_q;
        err_d         = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    is_store_d    = bus.is_store;
                    size_d        = bus.size;
                    is_unsigned_d = bus.is_unsigned;
                    addr_d        = bus.addr;
                    store_data_d  = bus.store_data;
                    if (misaligned(bus.size, bus.addr[2:0])) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else if (bus.is_store && (bus.size == 2'b11)) begin
                        state_d     = WR;
                        mem_wdata_d = bus.store_data;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            RD:  state_d = CAP;
            CAP: begin
                if (is_store_q) begin
                    state_d     = WR;
                    mem_wdata_d = merged;
                end else begin
                    state_d     = DONE;
                    load_data_d = load_ext;
                end
            end
            WR:      state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they follow the state being entered.
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
        mem_wr_d = (state_d == WR);
        if ((state_d == RD) || (state_d == CAP) || (state_d == WR)) begin
            mem_addr_d = {addr_d[ADDR_W-1:3], 3'b000};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            is_store_q    <= 1'b0;
            size_q        <= 2'b00;
            is_unsigned_q <= 1'b0;
            addr_q        <= '0;
            store_data_q  <= '0;
            mem_addr_q    <= '0;
            mem_wr_q      <= 1'b0;
            mem_wdata_q   <= '0;
            load_data_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            is_store_q    <= is_store_d;
            size_q        <= size_d;
            is_unsigned_q <= is_unsigned_d;
            addr_q        <= addr_d;
            store_data_q  <= store_data_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_q      <= mem_wr_d;
            mem_wdata_q   <= mem_wdata_d;
            load_data_q   <= load_data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.load_data = load_data_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed and random loads/stores against a byte-level reference model.
module tb_mem_access_ctrl;
    localparam int unsigned ADDR_W = 64;

    logic clock = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    logic [63:0] exp_ld;

    always #5 clock = ~clock;

    mem_access_ctrl_if #(.ADDR_W(ADDR_W)) bus();

    mem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    function automatic bit model_mis(input logic [1:0] sz, input logic [63:0] a);
        int n = 1 << sz;
        return (a % 64'(n)) != 0;
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] w, input logic [1:0] sz,
                                               input logic uns, input int off);
        int n = 1 << sz;
        logic [63:0] v = 0;
        for (int j = 0; j < n; j++) v |= ((w >> (8 * (off + j))) & 64'hFF) << (8 * j);
        if (sz != 2'b11 && !uns && v[8*n-1]) v |= ~((64'd1 << (8 * n)) - 64'd1);
        return v;
    endfunction

    function automatic logic [63:0] model_merge(input logic [63:0] w, input logic [63:0] sd,
                                                input logic [1:0] sz, input int off);
        int n = 1 << sz;
        logic [7:0]  b [8];
        logic [63:0] r = 0;
        for (int i = 0; i < 8; i++) b[i] = w[8*i +: 8];
        for (int j = 0; j < n; j++) b[off + j] = sd[8*j +: 8];
        for (int i = 0; i < 8; i++) r |= 64'(b[i]) << (8 * i);
        return r;
    endfunction

    // Caller is 1 time unit after a rising edge with the DUT idle.
    task automatic run_op(input string tag, input bit st, input logic [1:0] sz, input bit uns,
                          input logic [63:0] a, input logic [63:0] sd, input logic [63:0] word,
                          input bit hold);
        bit          mis = model_mis(sz, a);
        int          lat = mis ? 1 : (!st ? 3 : (sz == 2'b11 ? 2 : 4));
        bit          exp_wr = st && !mis;
        logic [63:0] exp_addr = {a[63:3], 3'b000};
        int          done_cyc = -1;
        int          wr_cnt = 0;
        int          wr_cyc = -1;
        logic [63:0] wr_data = 0;
        logic [63:0] wr_addr = 0;
        logic [63:0] ld = 0;
        logic        err_at = 0;
        logic        busy1 = 0;
        bit          prev_hit = 0;

        bus.is_store    = st;
        bus.size        = sz;
        bus.is_unsigned = uns;
        bus.addr        = a;
        bus.store_data  = sd;
        bus.start       = 1'b1;
        for (int k = 1; k <= 12 && done_cyc < 0; k++) begin
            @(posedge clock); #1;
            if (!hold || bus.done) bus.start = 1'b0;
            if (k == 1) busy1 = bus.busy;
            if (bus.mem_wr) begin
                wr_cnt++; wr_cyc = k; wr_data = bus.mem_wdata; wr_addr = bus.mem_addr;
            end
            if (bus.done) begin
                done_cyc = k; err_at = bus.err; ld = bus.load_data;
            end
            bus.mem_rdata = prev_hit ? word : {$urandom, $urandom};
            prev_hit = bus.busy && !bus.mem_wr && (bus.mem_addr == exp_addr);
        end
        bus.start = 1'b0;

        if (!st && !mis) exp_ld = model_load(word, sz, uns, int'(a[2:0]));
        check($sformatf("%s.done_cycle", tag), 64'(done_cyc), 64'(lat));
        check($sformatf("%s.err", tag), 64'(err_at), 64'(mis));
        check($sformatf("%s.busy", tag), 64'(busy1), 64'd1);
        check($sformatf("%s.wr_count", tag), 64'(wr_cnt), 64'(exp_wr));
        if (exp_wr) begin
            check($sformatf("%s.wr_cycle", tag), 64'(wr_cyc), 64'(lat - 1));
            check($sformatf("%s.wr_addr", tag), wr_addr, exp_addr);
            check($sformatf("%s.wr_data", tag), wr_data, model_merge(word, sd, sz, int'(a[2:0])));
        end
        check($sformatf("%s.load_data", tag), ld, exp_ld);

        @(posedge clock); #1;
        bus.mem_rdata = {$urandom, $urandom};
        check($sformatf("%s.idle_done", tag), 64'(bus.done), 64'd0);
        check($sformatf("%s.idle_busy", tag), 64'(bus.busy), 64'd0);
        check($sformatf("%s.idle_wr", tag), 64'(bus.mem_wr), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check($sformatf("%s.busy", tag), 64'(bus.busy), 64'd0);
        check($sformatf("%s.done", tag), 64'(bus.done), 64'd0);
        check($sformatf("%s.err", tag), 64'(bus.err), 64'd0);
        check($sformatf("%s.mem_wr", tag), 64'(bus.mem_wr), 64'd0);
        check($sformatf("%s.mem_addr", tag), bus.mem_addr, 64'd0);
        check($sformatf("%s.mem_wdata", tag), bus.mem_wdata, 64'd0);
        check($sformatf("%s.load_data", tag), bus.load_data, 64'd0);
    endtask

    initial begin
        logic [1:0]  sz;
        logic [63:0] a;
        reset           = 1'b1;
        bus.start       = 1'b0;
        bus.is_store    = 1'b0;
        bus.size        = 2'b00;
        bus.is_unsigned = 1'b0;
        bus.addr        = '0;
        bus.store_data  = '0;
        bus.mem_rdata   = '0;
        exp_ld          = '0;

        @(posedge clock); #1;
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clock); #1;

        run_op("lb_signed", 1'b0, 2'b00, 1'b0, 64'h103, 64'h0, 64'h0000_0000_8000_0000, 1'b0);
        check("lb_signed.literal", bus.load_data, 64'hFFFF_FFFF_FFFF_FF80);
        run_op("lw_unsigned", 1'b0, 2'b10, 1'b1, 64'h104, 64'h0, 64'hDEAD_BEEF_0000_0001, 1'b1);
        check("lw_unsigned.literal", bus.load_data, 64'h0000_0000_DEAD_BEEF);
        run_op("sh_rmw", 1'b1, 2'b01, 1'b0, 64'h202, 64'h5555_6666_7777_ABCD,
               64'h1111_2222_3333_4444, 1'b1);
        run_op("sd", 1'b1, 2'b11, 1'b0, 64'h208, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b1);
        run_op("lw_misaligned", 1'b0, 2'b10, 1'b0, 64'h20A, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        run_op("sh_misaligned", 1'b1, 2'b01, 1'b0, 64'h301, 64'hFFFF, 64'h0, 1'b0);
        run_op("ld_double", 1'b0, 2'b11, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0,
               64'h8765_4321_0FED_CBA9, 1'b0);
        run_op("lh_signed_top", 1'b0, 2'b01, 1'b0, 64'h406, 64'h0, 64'hF00D_0000_0000_0000, 1'b0);
        run_op("sb_top", 1'b1, 2'b00, 1'b0, 64'h407, 64'h99, 64'h0011_2233_4455_6677, 1'b0);

        // Abort a read-modify-write store while it sits in its write cycle.
        bus.is_store = 1'b1; bus.size = 2'b01; bus.is_unsigned = 1'b0;
        bus.addr = 64'h202; bus.store_data = 64'hABCD; bus.start = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        bus.mem_rdata = 64'h1111_2222_3333_4444;
        @(posedge clock); #1;
        check("rst_mid.in_wr", 64'(bus.mem_wr), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("rst_mid");
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        bus.start = 1'b0;
        exp_ld = '0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            check("rst_after.done", 64'(bus.done), 64'd0);
            check("rst_after.wr", 64'(bus.mem_wr), 64'd0);
        end
        run_op("cold_lb", 1'b0, 2'b00, 1'b0, 64'h103, 64'h0, 64'h0000_0000_8000_0000, 1'b1);

        for (int t = 0; t < 40; t++) begin
            sz = 2'($urandom_range(0, 3));
            a  = {$urandom, $urandom};
            if ($urandom_range(0, 2) != 0) a = a & ~((64'd1 << sz) - 64'd1);
            run_op($sformatf("rand%0d", t), 1'($urandom), sz, 1'($urandom), a,
                   {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 64, meaning the byte-address width of the request and memory address.
REQ-002 The block SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, request strobe, sampled only in IDLE.
REQ-005 The block SHALL have port is_store, input, 1, 1 = store, 0 = load.
REQ-006 The block SHALL have port size, input, 2, access size: 00 byte, 01 half, 10 word, 11 double.
REQ-007 The block SHALL have port is_unsigned, input, 1, zero-extend loads; ignored for double and for stores.
REQ-008 The block SHALL have port addr, input, ADDR_W, byte address of the access.
REQ-009 The block SHALL have port store_data, input, 64, store operand, least-significant bytes used.
REQ-010 The block SHALL have port mem_rdata, input, 64, data-memory read data, valid one cycle after a read address is presented.
REQ-011 The block SHALL have port mem_addr, output, ADDR_W, doubleword-aligned memory address {addr[ADDR_W-1:3],3'b000}.
REQ-012 The block SHALL have port mem_wr, output, 1, memory write enable, one cycle per write.
REQ-013 The block SHALL have port mem_wdata, output, 64, memory write data.
REQ-014 The block SHALL have port load_data, output, 64, extended load result, held until the next accepted request.
REQ-015 The block SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-016 The block SHALL have port done, output, 1, single-cycle completion pulse.
REQ-017 The block SHALL have port err, output, 1, misalignment flag, valid only with done.

Function
REQ-018 The block SHALL implement states IDLE, RD, CAP, WR, DONE, with request fields (is_store, size, is_unsigned, addr, store_data) registered on the accepting edge.
REQ-019 The block SHALL treat a request as misaligned when: half with addr[0]=1; word with addr[1:0]!=0; double with addr[2:0]!=0.
REQ-020 On a misaligned request the block SHALL go IDLE->DONE, assert err=1 with done, and perform no memory access (mem_wr stays 0, load_data unchanged).
REQ-021 On an aligned load the block SHALL go IDLE->RD->CAP->DONE, giving done 3 cycles after the start edge, with mem_wr=0 throughout.
REQ-022 In CAP the block SHALL register load_data = (mem_rdata >> 8*addr[2:0]) truncated to size, then sign-extended (is_unsigned=0) or zero-extended (is_unsigned=1); double SHALL pass all 64 bits unchanged.
REQ-023 On an aligned double store the block SHALL go IDLE->WR->DONE, with mem_wr=1 and mem_wdata=store_data in WR, giving done 2 cycles after the start edge.
REQ-024 On an aligned byte, half or word store the block SHALL read-modify-write via IDLE->RD->CAP->WR->DONE, giving done 4 cycles after the start edge.
REQ-025 In CAP of a sub-doubleword store the block SHALL register merge = mem_rdata with bytes [off, off+n-1] replaced by store_data[8n-1:0], where off = addr[2:0] and n = 1, 2 or 4.
REQ-026 In WR of a sub-doubleword store the block SHALL drive mem_wdata = merge; all other mem_rdata bytes SHALL be preserved.
REQ-027 The block SHALL drive mem_addr from the registered address in RD, CAP and WR; mem_wr SHALL be 1 only in WR.
REQ-028 The block SHALL assert done for exactly one cycle in DONE and return to IDLE on the following edge; err SHALL be 0 for aligned requests.
REQ-029 The block SHALL ignore start while busy=1; start in IDLE on the cycle after DONE SHALL be accepted, giving back-to-back operation.
REQ-030 Store requests SHALL NOT alter load_data.

Reset
REQ-031 On reset assertion the block SHALL immediately, regardless of clock, set state=IDLE and busy=0, done=0, err=0, mem_wr=0, mem_addr=0, mem_wdata=0, load_data=0.
REQ-032 A reset during any state SHALL abort the access: no subsequent mem_wr and no done; the first request after reset release SHALL behave as from cold.

Verification
REQ-033 Load byte signed at addr 0x103, mem_rdata 0x0000_0000_8000_0000 -> done at cycle +3, load_data 0xFFFF_FFFF_FFFF_FF80, err 0.
REQ-034 Load word unsigned at addr 0x104, mem_rdata 0xDEAD_BEEF_0000_0001 -> load_data 0x0000_0000_DEAD_BEEF.
REQ-035 Store half 0xABCD at addr 0x202, mem_rdata 0x1111_2222_3333_4444 -> single write in cycle +3, mem_addr 0x200, mem_wdata 0x1111_2222_ABCD_4444, done at cycle +4.
REQ-036 Store double at addr 0x208 -> mem_wr in cycle +1 only, done at cycle +2; then load word at 0x20A -> done at cycle +1, err 1, no mem_wr.
REQ-037 Reset asserted mid-clock while in WR -> all outputs 0 at once, no done; start held high during busy -> no second access.
